// File: rtl/ram_port_arbiter_if.sv
// Requester-side bus for one port of ram_port_arbiter.
// The requester drives a req/gnt transaction and receives a one-cycle response.
interface ram_port_arbiter_if;
    logic        req;
    logic        we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        gnt;
    logic        rvalid;
    logic [31:0] rdata;
    logic        err;

    modport master (
        output req, we, be, addr, wdata,
        input  gnt, rvalid, rdata, err
    );

    modport slave (
        input  req, we, be, addr, wdata,
        output gnt, rvalid, rdata, err
    );
endinterface

// File: rtl/ram_port_arbiter.sv
// ram_port_arbiter: shares one single-port, read-first, byte-write RAM with
// registered read data between the data port (p0) and the fetch port (p1).
// One access is granted per cycle and its response is returned on the
// granted port exactly one cycle later. Addresses at or beyond SIZE*4 are
// answered with an error and never reach the RAM.
// Build option: define ARB_ROUND_ROBIN_EN for round-robin contention
// handling; otherwise port 0 has fixed priority.
module ram_port_arbiter #(
    parameter int SIZE       = 4096,
    parameter int ADDR_WIDTH = $clog2(SIZE * 4)
) (
    input  logic                  clk,
    input  logic                  rst,
    ram_port_arbiter_if.slave     p0,
    ram_port_arbiter_if.slave     p1,
    output logic [3:0]            ram_we,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic [31:0]           ram_di,
    input  logic [31:0]           ram_dout
);

    localparam logic [31:0] BYTE_LIMIT = 32'(SIZE * 4);

    typedef enum logic {
        IDLE = 1'b0,
        RESP = 1'b1
    } state_t;

    state_t      state_reg, state_next;
    logic        resp_port_reg, resp_port_next;
    logic        resp_err_reg, resp_err_next;
    logic        resp_valid;

    logic        prefer_p0;
    logic        gnt0, gnt1, any_gnt;
    logic        sel_we;
    logic [3:0]  sel_be;
    logic [31:0] sel_addr;
    logic [31:0] sel_wdata;
    logic        in_range;

`ifdef ARB_ROUND_ROBIN_EN
    logic        last_reg, last_next;

    // On contention the port that was not granted last wins.
    assign prefer_p0 = last_reg;

    // Remember the most recently granted port.
    always_comb begin
        last_next = last_reg;
        if (any_gnt) begin
            last_next = gnt1;
        end
    end

    // Round-robin pointer; resets to 1 so port 0 wins the first contention.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_reg <= 1'b1;
        end else begin
            last_reg <= last_next;
        end
    end
`else
    // Fixed priority: port 0 always wins contention.
    assign prefer_p0 = 1'b1;
`endif

    // Arbitration, request mux and RAM drive; nothing is granted in reset.
    always_comb begin
        gnt0      = 1'b0;
        gnt1      = 1'b0;
        sel_we    = 1'b0;
        sel_be    = 4'b0000;
        sel_addr  = 32'h0;
        sel_wdata = 32'h0;
        ram_we    = 4'b0000;
        ram_addr  = '0;
        ram_di    = 32'h0;
        if (!rst) begin
            gnt0 = p0.req && (!p1.req || prefer_p0);
            gnt1 = p1.req && !gnt0;
        end
        any_gnt = gnt0 || gnt1;
        if (gnt0) begin
            sel_we    = p0.we;
            sel_be    = p0.be;
            sel_addr  = p0.addr;
            sel_wdata = p0.wdata;
        end else if (gnt1) begin
            sel_we    = p1.we;
            sel_be    = p1.be;
            sel_addr  = p1.addr;
            sel_wdata = p1.wdata;
        end
        in_range = (sel_addr < BYTE_LIMIT);
        // Error accesses leave the RAM untouched.
        if (any_gnt && in_range) begin
            ram_addr = sel_addr[ADDR_WIDTH-1:0];
            if (sel_we) begin
                ram_we = sel_be;
                ram_di = sel_wdata;
            end
        end
    end

    assign p0.gnt = gnt0;
    assign p1.gnt = gnt1;

    // Response FSM: any grant leads to a response cycle, otherwise idle.
    always_comb begin
        state_next     = IDLE;
        resp_port_next = resp_port_reg;
        resp_err_next  = 1'b0;
        if (any_gnt) begin
            state_next     = RESP;
            resp_port_next = gnt1;
            resp_err_next  = !in_range;
        end
    end

    // Response state registers; reset drops any pending response.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg     <= IDLE;
            resp_port_reg <= 1'b0;
            resp_err_reg  <= 1'b0;
        end else begin
            state_reg     <= state_next;
            resp_port_reg <= resp_port_next;
            resp_err_reg  <= resp_err_next;
        end
    end

    assign resp_valid = (state_reg == RESP);

    // Route the response to the port that owned the access; idle port sees 0.
    always_comb begin
        p0.rvalid = resp_valid && !resp_port_reg;
        p1.rvalid = resp_valid && resp_port_reg;
        p0.err    = p0.rvalid && resp_err_reg;
        p1.err    = p1.rvalid && resp_err_reg;
        p0.rdata  = (p0.rvalid && !resp_err_reg) ? ram_dout : 32'h0;
        p1.rdata  = (p1.rvalid && !resp_err_reg) ? ram_dout : 32'h0;
    end

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Testbench for ram_port_arbiter: table of single-port transactions with
// hand-computed results, plus sequences for reset, mid-transaction reset and
// contention. A behavioural read-first RAM sits on the RAM side.
module tb_ram_port_arbiter;
    localparam int SIZE = 4096;
    localparam int AW   = $clog2(SIZE * 4);
    localparam int NV   = 12;

    logic          clk = 1'b0;
    logic          rst;
    logic          mem_clr;
    logic [3:0]    ram_we;
    logic [AW-1:0] ram_addr;
    logic [31:0]   ram_di;
    logic [31:0]   ram_dout;
    logic [31:0]   mem [0:SIZE-1];

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic        port;
        logic        we;
        logic [3:0]  be;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        exp_err;
        logic [31:0] exp_rdata;
        logic [3:0]  exp_ram_we;
    } vec_t;

    vec_t vecs [NV];

    ram_port_arbiter_if p0_if ();
    ram_port_arbiter_if p1_if ();

    ram_port_arbiter #(.SIZE(SIZE)) dut (
        .clk      (clk),
        .rst      (rst),
        .p0       (p0_if),
        .p1       (p1_if),
        .ram_we   (ram_we),
        .ram_addr (ram_addr),
        .ram_di   (ram_di),
        .ram_dout (ram_dout)
    );

    always #5 clk = ~clk;

    // Behavioural RAM: read-first, byte writes, registered read data.
    always @(posedge clk) begin
        if (mem_clr) begin
            for (int j = 0; j < SIZE; j++) mem[j] <= 32'h0;
            ram_dout <= 32'h0;
        end else begin
            ram_dout <= mem[ram_addr[AW-1:2]];
            for (int b = 0; b < 4; b++)
                if (ram_we[b]) mem[ram_addr[AW-1:2]][8*b +: 8] <= ram_di[8*b +: 8];
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic port, input logic req, input logic we, input logic [3:0] be,
                         input logic [31:0] addr, input logic [31:0] wdata);
        if (!port) begin
            p0_if.req = req; p0_if.we = we; p0_if.be = be; p0_if.addr = addr; p0_if.wdata = wdata;
        end else begin
            p1_if.req = req; p1_if.we = we; p1_if.be = be; p1_if.addr = addr; p1_if.wdata = wdata;
        end
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        drive(1'b1, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    endtask

    initial begin
        logic        exp_p0_win;
        logic [31:0] exp_data;

        // port, we, be, addr, wdata, exp_err, exp_rdata, exp_ram_we
        vecs[0]  = '{1'b0, 1'b1, 4'hF, 32'h0000_0010, 32'hDEAD_BEEF, 1'b0, 32'h0000_0000, 4'hF};
        vecs[1]  = '{1'b0, 1'b0, 4'hF, 32'h0000_0010, 32'h0,         1'b0, 32'hDEAD_BEEF, 4'h0};
        vecs[2]  = '{1'b0, 1'b1, 4'h2, 32'h0000_0010, 32'h0000_AA00, 1'b0, 32'hDEAD_BEEF, 4'h2};
        vecs[3]  = '{1'b0, 1'b0, 4'hF, 32'h0000_0010, 32'h0,         1'b0, 32'hDEAD_AAEF, 4'h0};
        vecs[4]  = '{1'b1, 1'b0, 4'hF, 32'h0000_4000, 32'h0,         1'b1, 32'h0000_0000, 4'h0};
        vecs[5]  = '{1'b0, 1'b1, 4'hF, 32'h0000_0020, 32'h1234_5678, 1'b0, 32'h0000_0000, 4'hF};
        vecs[6]  = '{1'b1, 1'b0, 4'hF, 32'h0000_0020, 32'h0,         1'b0, 32'h1234_5678, 4'h0};
        vecs[7]  = '{1'b1, 1'b0, 4'hF, 32'h0000_0013, 32'h0,         1'b0, 32'hDEAD_AAEF, 4'h0};
        vecs[8]  = '{1'b0, 1'b1, 4'hF, 32'hFFFF_FFFC, 32'hCAFE_F00D, 1'b1, 32'h0000_0000, 4'h0};
        vecs[9]  = '{1'b1, 1'b0, 4'hF, 32'h0000_3FFC, 32'h0,         1'b0, 32'h0000_0000, 4'h0};
        vecs[10] = '{1'b1, 1'b1, 4'h1, 32'h0000_3FFC, 32'h0000_00A5, 1'b0, 32'h0000_0000, 4'h1};
        vecs[11] = '{1'b0, 1'b0, 4'hF, 32'h0000_3FFC, 32'h0,         1'b0, 32'h0000_00A5, 4'h0};

        // Reset with both ports requesting: nothing may be granted or written.
        rst = 1'b1;
        mem_clr = 1'b1;
        drive(1'b0, 1'b1, 1'b1, 4'hF, 32'h10, 32'h1111_1111);
        drive(1'b1, 1'b1, 1'b1, 4'hF, 32'h20, 32'h2222_2222);
        @(posedge clk); #1;
        check("rst_p0_gnt", p0_if.gnt, 1'b0);
        check("rst_p1_gnt", p1_if.gnt, 1'b0);
        check("rst_ram_we", ram_we, 4'h0);
        check("rst_p0_rvalid", p0_if.rvalid, 1'b0);
        check("rst_p1_rvalid", p1_if.rvalid, 1'b0);
        check("rst_p0_err", p0_if.err, 1'b0);
        check("rst_p0_rdata", p0_if.rdata, 32'h0);
        check("rst_p1_rdata", p1_if.rdata, 32'h0);
        $display("reset: gnt=%b%b ram_we=%h", p1_if.gnt, p0_if.gnt, ram_we);
        idle();
        mem_clr = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;

        // Back-to-back single-port transactions from the table.
        for (int k = 0; k < NV; k++) begin
            idle();
            drive(vecs[k].port, 1'b1, vecs[k].we, vecs[k].be, vecs[k].addr, vecs[k].wdata);
            #4;
            check($sformatf("v%0d_gnt", k), vecs[k].port ? p1_if.gnt : p0_if.gnt, 1'b1);
            check($sformatf("v%0d_other_gnt", k), vecs[k].port ? p0_if.gnt : p1_if.gnt, 1'b0);
            check($sformatf("v%0d_ram_we", k), ram_we, vecs[k].exp_ram_we);
            if (!vecs[k].exp_err)
                check($sformatf("v%0d_ram_addr", k), ram_addr, vecs[k].addr[AW-1:0]);
            if (vecs[k].exp_ram_we != 4'h0)
                check($sformatf("v%0d_ram_di", k), ram_di, vecs[k].wdata);
            @(posedge clk); #1;
            check($sformatf("v%0d_rvalid", k), vecs[k].port ? p1_if.rvalid : p0_if.rvalid, 1'b1);
            check($sformatf("v%0d_other_rvalid", k), vecs[k].port ? p0_if.rvalid : p1_if.rvalid, 1'b0);
            check($sformatf("v%0d_err", k), vecs[k].port ? p1_if.err : p0_if.err, vecs[k].exp_err);
            check($sformatf("v%0d_rdata", k), vecs[k].port ? p1_if.rdata : p0_if.rdata, vecs[k].exp_rdata);
            $display("vec %0d: port=%0d we=%0d addr=%h err=%0d rdata=%h",
                     k, vecs[k].port, vecs[k].we, vecs[k].addr,
                     vecs[k].port ? p1_if.err : p0_if.err,
                     vecs[k].port ? p1_if.rdata : p0_if.rdata);
        end

        // No request: RAM outputs idle, and the last response lasts one cycle.
        idle();
        #4;
        check("idle_gnt", {p1_if.gnt, p0_if.gnt}, 2'b00);
        check("idle_ram_we", ram_we, 4'h0);
        check("idle_ram_addr", ram_addr, 0);
        check("idle_ram_di", ram_di, 32'h0);
        @(posedge clk); #1;
        check("idle_rvalid", {p1_if.rvalid, p0_if.rvalid}, 2'b00);
        $display("idle: rvalid=%b%b", p1_if.rvalid, p0_if.rvalid);

        // Reset lands before the response edge of a granted write.
        drive(1'b0, 1'b1, 1'b1, 4'hF, 32'h30, 32'h5555_5555);
        #4;
        check("mid_gnt_before", p0_if.gnt, 1'b1);
        check("mid_ram_we_before", ram_we, 4'hF);
        rst = 1'b1;
        #1;
        check("mid_gnt_in_rst", p0_if.gnt, 1'b0);
        check("mid_ram_we_in_rst", ram_we, 4'h0);
        @(posedge clk); #1;
        check("mid_p0_rvalid", p0_if.rvalid, 1'b0);
        check("mid_p1_rvalid", p1_if.rvalid, 1'b0);
        check("mid_p0_err", p0_if.err, 1'b0);
        check("mid_p0_rdata", p0_if.rdata, 32'h0);
        $display("mid reset: rvalid=%b%b", p1_if.rvalid, p0_if.rvalid);
        idle();
        @(posedge clk); #1;
        rst = 1'b0;

        // Continuous contention: p0 reads 0x10, p1 reads 0x20.
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, 1'b1, 1'b0, 4'hF, 32'h10, 32'h0);
            drive(1'b1, 1'b1, 1'b0, 4'hF, 32'h20, 32'h0);
`ifdef ARB_ROUND_ROBIN_EN
            exp_p0_win = ((i % 2) == 0);
`else
            exp_p0_win = 1'b1;
`endif
            exp_data = exp_p0_win ? 32'hDEAD_AAEF : 32'h1234_5678;
            #4;
            check($sformatf("c%0d_p0_gnt", i), p0_if.gnt, exp_p0_win);
            check($sformatf("c%0d_p1_gnt", i), p1_if.gnt, !exp_p0_win);
            @(posedge clk); #1;
            check($sformatf("c%0d_p0_rvalid", i), p0_if.rvalid, exp_p0_win);
            check($sformatf("c%0d_p1_rvalid", i), p1_if.rvalid, !exp_p0_win);
            check($sformatf("c%0d_rdata", i), exp_p0_win ? p0_if.rdata : p1_if.rdata, exp_data);
            $display("contend %0d: rvalid=%b%b rdata0=%h rdata1=%h",
                     i, p1_if.rvalid, p0_if.rvalid, p0_if.rdata, p1_if.rdata);
        end

        // p0 drops its request; p1 is served on its own.
        drive(1'b0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        #4;
        check("solo_p1_gnt", p1_if.gnt, 1'b1);
        check("solo_p0_gnt", p0_if.gnt, 1'b0);
        @(posedge clk); #1;
        check("solo_p1_rvalid", p1_if.rvalid, 1'b1);
        check("solo_p1_rdata", p1_if.rdata, 32'h1234_5678);
        $display("solo p1: rvalid=%b rdata=%h", p1_if.rvalid, p1_if.rdata);
        idle();
        @(posedge clk); #1;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/ram_port_arbiter.md
# ram_port_arbiter

Two-requester arbiter that shares one single-port byte-write RAM (read-first, 32-bit words, registered read data, 1-cycle latency) between the core's data port (port 0) and instruction-fetch port (port 1). It accepts req/gnt-style transactions on each port, picks one per cycle, and drives the RAM's byte write enables, address and write data. It returns a response (`rvalid`/`rdata`/`err`) to the granted port exactly one cycle later. Out-of-range addresses are answered with an error and never reach the RAM.

## Interface
- `SIZE`, 4096, RAM depth in 32-bit words
- `ADDR_WIDTH`, $clog2(SIZE*4), RAM byte-address width
- `clk` in 1 — single clock, all logic rising-edge
- `rst` in 1 — asynchronous, active-high reset
- `p0_req`, `p1_req` in 1 — transaction request
- `p0_we`, `p1_we` in 1 — 1 = write, 0 = read
- `p0_be`, `p1_be` in 4 — byte enables, bit i = byte lane i
- `p0_addr`, `p1_addr` in 32 — byte address; bits [1:0] are ignored
- `p0_wdata`, `p1_wdata` in 32 — write data
- `p0_gnt`, `p1_gnt` out 1 — request accepted this cycle (combinational)
- `p0_rvalid`, `p1_rvalid` out 1 — response valid (registered)
- `p0_rdata`, `p1_rdata` out 32 — response data
- `p0_err`, `p1_err` out 1 — response is an error, qualified by rvalid
- `ram_we` out 4 — RAM byte write enables
- `ram_addr` out ADDR_WIDTH — RAM byte address
- `ram_di` out 32 — RAM write data
- `ram_dout` in 32 — RAM registered read data

## Operation
- Requester rule: hold `req` and all attributes stable until `gnt`. Deasserting `req` before `gnt` is permitted.
- Arbitration happens every cycle. At most one `gnt` is high per cycle. A grant is issued in the same cycle as `req` when that port wins.
- Contention policy is set by the macro (see Configuration).
- Range check: a granted request with `addr >= SIZE*4` is an error access.
  - `ram_we` = 0 for that access.
  - Next cycle: `rvalid` = 1, `err` = 1, `rdata` = 0.
- Valid read: `ram_we` = 0, `ram_addr` = `addr[ADDR_WIDTH-1:0]`. Next cycle: `rvalid` = 1, `rdata` = `ram_dout`, `err` = 0.
- Valid write: `ram_we` = `be`, `ram_di` = `wdata`. Next cycle: `rvalid` = 1, `err` = 0, `rdata` = `ram_dout`, which is the pre-write word (read-first).
- No grant: `ram_we` = 0, `ram_addr` = 0, `ram_di` = 0.
- Response state registers: `resp_valid`, `resp_port` (0/1), `resp_err`.
- `prdata`/`rdata` on the port without `rvalid` is driven 0.
- Response FSM is effectively two states:
  - IDLE → RESP on any grant.
  - RESP → RESP on a back-to-back grant; RESP → IDLE otherwise.
  - The RAM accepts one access per cycle, so full throughput is one transaction per cycle.

## Timing
- Request to `gnt`: 0 cycles. `gnt` to `rvalid`: 1 cycle, asserted for exactly one cycle.
- RAM control outputs are combinational from the winning request. The RAM samples them at the same edge that registers the response.
- Reset values: all `rvalid` = 0, all `err` = 0, all `rdata` = 0, `resp_port` = 0. Round-robin pointer `last` = 1, so port 0 wins the first contended cycle.
- While `rst` is high:
  - `gnt` = 0 and `ram_we` = 0 regardless of `req`.
- Reset asserted mid-transaction drops any pending response. No `rvalid` is issued for a grant whose response edge occurs during reset.
- Simultaneous requests resolve in the same cycle with no bubble. The loser keeps `req` high and is granted on a later cycle.
- Port 0 write and port 1 read to the same word on consecutive cycles: the read returns the newly written data.

## Configuration
- `ARB_ROUND_ROBIN_EN` defined:
  - On contention, grant the port that is not `last`.
  - `last` updates to the granted port on every grant, contended or not.
  - Worst-case wait is 1 cycle.
- Not defined:
  - Fixed priority, port 0 always wins contention.
  - Port 1 can starve.
  - No `last` register is built.

## Test plan
- Reset, then p0 write `addr`=0x10, `be`=4'b1111, `wdata`=0xDEADBEEF → `p0_gnt` same cycle, `ram_we`=4'hF. Next cycle `p0_rvalid`=1, `err`=0. A later p0 read of 0x10 returns 0xDEADBEEF.
- Partial write `be`=4'b0010, `wdata`=0x0000AA00 to 0x10 → a subsequent read of 0x10 returns 0xDEADAAEF.
- Both ports request reads continuously:
  - With `ARB_ROUND_ROBIN_EN`: grants alternate p0, p1, p0, p1, one `rvalid` per cycle.
  - Without it: p1 receives no `gnt` until p0 drops `req`.
- p1 read at `addr`=SIZE*4 (0x4000) → `p1_gnt`=1, `ram_we`=0. Next cycle `p1_rvalid`=1, `p1_err`=1, `p1_rdata`=0.
- p0 write of 0x12345678 to 0x20 immediately followed by a p1 read of 0x20 → `p1_rdata`=0x12345678. The write's own response returns the old word.
- Assert `rst` on the cycle after a grant → no `rvalid` issued, all outputs 0. Once reset is released, the first contended cycle grants p0.
